poly_synth_core: RTL and testbench

Polyphonic successor to the single-tone synth core. It tracks up to NUM_VOICES keypad keys held at the same time and runs one phase-accumulator oscillator per held key. Each voice produces a square, saw or triangle sample; the samples are mixed and driven out through a single-bit PWM DAC. It sits between the debounced keypad front end and the audio pin.

---
 rtl/synth_pkg.sv | 47 ++++
 rtl/pwm_dac.sv | 31 +++
 rtl/poly_synth_core.sv | 134 +++++++++++++
 tb/tb_poly_synth_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: waveform encoding, default widths and the phase-increment table shared by the synth core.
package synth_pkg;

    localparam int NUM_KEYS_DEF    = 13;
    localparam int NUM_VOICES_DEF  = 4;
    localparam int PHASE_BITS_DEF  = 24;
    localparam int SAMPLE_BITS_DEF = 8;
    localparam int CLK_HZ_DEF      = 10_000_000;

    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        SAW      = 2'd1,
        TRIANGLE = 2'd2
    } mode_e;

    // Note frequencies C4..C5 in millihertz.
    function automatic longint unsigned note_mhz(input int k);
        case (k)
            0:       return 64'd261626;
            1:       return 64'd277183;
            2:       return 64'd293665;
            3:       return 64'd311127;
            4:       return 64'd329628;
            5:       return 64'd349228;
            6:       return 64'd369994;
            7:       return 64'd391995;
            8:       return 64'd415305;
            9:       return 64'd440000;
            10:      return 64'd466164;
            11:      return 64'd493883;
            12:      return 64'd523251;
            default: return 64'd0;
        endcase
    endfunction

    // round(f * 2^phase_bits / clk_hz), done in integer millihertz.
    function automatic longint unsigned inc_of(input int k, input int clk_hz, input int phase_bits);
        longint unsigned den;
        den = 64'(clk_hz) * 64'd1000;
        return ((note_mhz(k) << phase_bits) + den / 2) / den;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        return (m == SQUARE) ? SAW : (m == SAW) ? TRIANGLE : SQUARE;
    endfunction

endpackage

// File: rtl/pwm_dac.sv
// pwm_dac: single-bit PWM DAC; free-running counter, duty latched from mix at wrap, held at 0 while disabled.
//   clk, n_rst : clock, async active-low reset
//   en         : enable; low forces counter, duty and output to 0
//   mix_i      : sample to convert
//   pwm_o      : registered PWM output
module pwm_dac #(
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic [S-1:0] mix_i,
    output logic         pwm_o
);

    logic [S-1:0] cnt_q;
    logic [S-1:0] duty_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst || !en) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_o  <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            duty_q <= (&cnt_q) ? mix_i : duty_q;
            pwm_o  <= cnt_q < duty_q;
        end
    end

endmodule

// File: rtl/poly_synth_core.sv
// poly_synth_core: polyphonic keypad synth; voice allocation, per-voice oscillators, mixer and PWM output.
//   clk, n_rst   : clock, async active-low reset
//   en           : synth enable; low frees all voices
//   keypad_i     : [NUM_KEYS-1:0] note keys, [NUM_KEYS] mode key
//   pwm_o        : audio PWM
//   voice_busy_o : one bit per allocated voice
//   mode_o       : current waveform
module poly_synth_core
    import synth_pkg::*;
#(
    parameter int NUM_KEYS    = NUM_KEYS_DEF,
    parameter int NUM_VOICES  = NUM_VOICES_DEF,
    parameter int PHASE_BITS  = PHASE_BITS_DEF,
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int CLK_HZ      = CLK_HZ_DEF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic [NUM_KEYS:0]     keypad_i,
    output logic                  pwm_o,
    output logic [NUM_VOICES-1:0] voice_busy_o,
    output logic [1:0]            mode_o
);

    localparam int S  = SAMPLE_BITS;
    localparam int KW = $clog2(NUM_KEYS);
    localparam int KN = 2 ** KW;
    localparam int LV = $clog2(NUM_VOICES);
    localparam int VW = (LV > 0) ? LV : 1;

    logic [KN-1:0]         keys, owned, cand;
    logic [NUM_VOICES-1:0] busy_q, busy_d, alloc;
    logic [KW-1:0]         key_q [NUM_VOICES];
    logic [KW-1:0]         key_d [NUM_VOICES];
    logic [PHASE_BITS-1:0] phase_q [NUM_VOICES];
    logic [PHASE_BITS-1:0] phase_d [NUM_VOICES];
    logic [PHASE_BITS-1:0] inc_tab [KN];
    logic [S-1:0]          samp [NUM_VOICES];
    logic [S+LV-1:0]       sum;
    logic [S-1:0]          mix_q;
    logic [KW-1:0]         tgt;
    logic                  tgt_ok, v_ok;
    logic [VW-1:0]         vsel;
    mode_e                 mode_q, mode_d;
    logic                  mkey_q;

    assign keys         = KN'(keypad_i[NUM_KEYS-1:0]);
    assign voice_busy_o = busy_q;
    assign mode_o       = mode_q;
    assign mode_d       = (keypad_i[NUM_KEYS] && !mkey_q) ? next_mode(mode_q) : mode_q;

    for (genvar k = 0; k < KN; k++) begin : g_inc
        localparam longint unsigned INC = inc_of(k, CLK_HZ, PHASE_BITS);
        assign inc_tab[k] = INC[PHASE_BITS-1:0];
    end

    // One allocation per cycle: lowest unowned pressed key into lowest free voice.
    // Free status comes from busy_q, so a voice released this edge is not reused until the next.
    always_comb begin
        owned  = '0;
        tgt_ok = 1'b0;
        tgt    = '0;
        v_ok   = 1'b0;
        vsel   = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (busy_q[v]) owned[key_q[v]] = 1'b1;
        cand = keys & ~owned;
        for (int k = KN - 1; k >= 0; k--)
            if (cand[k]) begin
                tgt_ok = 1'b1;
                tgt    = KW'(k);
            end
        for (int v = NUM_VOICES - 1; v >= 0; v--)
            if (!busy_q[v]) begin
                v_ok = 1'b1;
                vsel = VW'(v);
            end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic keep;
        logic msb;
        assign keep       = en && busy_q[v] && keys[key_q[v]];
        assign msb        = phase_q[v][PHASE_BITS-1];
        assign alloc[v]   = en && tgt_ok && v_ok && (vsel == VW'(v));
        assign busy_d[v]  = keep || alloc[v];
        assign key_d[v]   = alloc[v] ? tgt : key_q[v];
        assign phase_d[v] = keep ? phase_q[v] + inc_tab[key_q[v]] : '0;
        assign samp[v]    = !busy_q[v]        ? '0 :
                            mode_q == SQUARE  ? (msb ? '0 : '1) :
                            mode_q == SAW     ? phase_q[v][PHASE_BITS-1 -: S] :
                            msb               ? ~phase_q[v][PHASE_BITS-2 -: S] :
                                                 phase_q[v][PHASE_BITS-2 -: S];
    end

    // Fixed divide by voice count keeps loudness per voice constant as voices come and go.
    always_comb begin
        sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            sum = sum + (S + LV)'(samp[v]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q <= '0;
            mix_q  <= '0;
            mode_q <= SQUARE;
            mkey_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_q[v]   <= '0;
                phase_q[v] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            mix_q  <= S'(sum >> LV);
            mode_q <= mode_d;
            mkey_q <= keypad_i[NUM_KEYS];
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_q[v]   <= key_d[v];
                phase_q[v] <= phase_d[v];
            end
        end
    end

    pwm_dac #(.S(S)) u_dac (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (en),
        .mix_i (mix_q),
        .pwm_o (pwm_o)
    );

endmodule

// File: tb/tb_poly_synth_core.sv
// tb_poly_synth_core: directed self-checking bench for poly_synth_core.
module tb_poly_synth_core;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en;
    logic [13:0] keypad;
    logic        pwm_o;
    logic [3:0]  voice_busy_o;
    logic [1:0]  mode_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    poly_synth_core dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en),
        .keypad_i     (keypad),
        .pwm_o        (pwm_o),
        .voice_busy_o (voice_busy_o),
        .mode_o       (mode_o)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic count_pwm(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            h += int'(pwm_o);
        end
    endtask

    task automatic mode_pulse();
        keypad[13] = 1'b1;
        tick(1);
        keypad[13] = 1'b0;
        tick(1);
    endtask

    initial begin
        int hi, per, h, m, prev, drops, dfrom, dto, mx, st, viol, t1, t2, t3, t4, d;
        n_rst  = 1'b0;
        en     = 1'b0;
        keypad = '0;
        tick(3);
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_busy", int'(voice_busy_o), 0);
        chk("rst_mode", int'(mode_o), 0);
        n_rst = 1'b1;
        en    = 1'b1;
        tick(2);
        chk("idle_busy", int'(voice_busy_o), 0);

        // A4 square: busy next cycle, mix 63 for the high half, period ~22733
        keypad[9] = 1'b1;
        tick(1);
        chk("a4_busy", int'(voice_busy_o), 1);
        tick(1);
        chk("a4_mix_hi", int'(dut.mix_q), 63);
        hi = 0; per = 0; h = 0;
        for (int i = 1; i <= 30000; i++) begin
            tick(1);
            if (i >= 1000 && i < 1256) h += int'(pwm_o);
            if (hi == 0 && dut.mix_q == 0) hi = i;
            if (hi != 0 && dut.mix_q == 63) begin
                per = i;
                break;
            end
        end
        chk("a4_pwm_duty", h, 63);
        chk("a4_half_ok", int'(hi >= 11366 && hi <= 11368), 1);
        chk("a4_period_ok", int'(per >= 22732 && per <= 22734), 1);
        keypad[9] = 1'b0;
        tick(1);
        chk("a4_release", int'(voice_busy_o), 0);
        tick(2);

        // Five keys, four voices
        keypad = 14'b01_0000_1001_0101;
        tick(1); chk("chord_b1", int'(voice_busy_o), 4'b0001);
        tick(1); chk("chord_b2", int'(voice_busy_o), 4'b0011);
        tick(1); chk("chord_b3", int'(voice_busy_o), 4'b0111);
        tick(1); chk("chord_b4", int'(voice_busy_o), 4'b1111);
        tick(1); chk("chord_full", int'(voice_busy_o), 4'b1111);
        chk("chord_k1", int'(dut.key_q[1]), 2);
        chk("chord_k3", int'(dut.key_q[3]), 7);
        keypad[2] = 1'b0;
        tick(1); chk("chord_free1", int'(voice_busy_o), 4'b1101);
        tick(1); chk("chord_realloc", int'(voice_busy_o), 4'b1111);
        chk("chord_k1_new", int'(dut.key_q[1]), 12);
        keypad = '0;
        tick(1); chk("chord_off", int'(voice_busy_o), 0);

        // Mode key
        mode_pulse(); chk("mode_p1", int'(mode_o), 1);
        mode_pulse(); chk("mode_p2", int'(mode_o), 2);
        mode_pulse(); chk("mode_p3", int'(mode_o), 0);
        keypad[13] = 1'b1;
        tick(100);
        keypad[13] = 1'b0;
        tick(1);
        chk("mode_hold", int'(mode_o), 1);

        // SAW on C4: monotonic ramp with a single 63->0 wrap
        keypad[0] = 1'b1;
        prev = 0; drops = 0; dfrom = -1; dto = -1; mx = 0;
        for (int i = 0; i < 38400; i++) begin
            tick(1);
            m = int'(dut.mix_q);
            if (m < prev) begin
                drops++;
                dfrom = prev;
                dto   = m;
            end
            if (m > mx) mx = m;
            prev = m;
        end
        chk("saw_drops", drops, 1);
        chk("saw_max", mx, 63);
        chk("saw_wrap_from", dfrom, 63);
        chk("saw_wrap_to", dto, 0);
        keypad[0] = 1'b0;
        tick(2);

        // TRIANGLE on C5: rise and fall symmetric around the midpoint
        mode_pulse();
        chk("mode_tri", int'(mode_o), 2);
        keypad[12] = 1'b1;
        prev = 0; st = 0; viol = 0; t1 = 0; t2 = 0; t3 = 0; t4 = 0;
        for (int i = 1; i <= 20000 && st != 4; i++) begin
            tick(1);
            m = int'(dut.mix_q);
            if (st == 0 && m != 0) begin
                t1 = i; st = 1;
            end else if (st == 1) begin
                if (m < prev) viol++;
                if (m == 63) begin t2 = i; st = 2; end
            end else if (st == 2 && m < 63) begin
                t3 = i; st = 3;
            end else if (st == 3) begin
                if (m > prev) viol++;
                if (m == 0) begin t4 = i; st = 4; end
            end
            prev = m;
        end
        d = (t2 - t1) - (t4 - t3);
        chk("tri_done", st, 4);
        chk("tri_monotonic", viol, 0);
        chk("tri_symmetric", int'(d >= -1 && d <= 1), 1);
        keypad[12] = 1'b0;
        tick(2);

        // en dropped mid-chord
        mode_pulse();
        chk("mode_sq", int'(mode_o), 0);
        keypad[0] = 1'b1; keypad[2] = 1'b1; keypad[4] = 1'b1;
        tick(3);
        chk("en_chord", int'(voice_busy_o), 4'b0111);
        tick(600);
        count_pwm(256, h);
        chk("en_chord_duty", h, 191);
        en = 1'b0;
        tick(1);
        chk("en_off_busy", int'(voice_busy_o), 0);
        chk("en_off_pwm", int'(pwm_o), 0);
        chk("en_off_mode", int'(mode_o), 0);
        count_pwm(50, h);
        chk("en_off_pwm_held", h, 0);
        mode_pulse();
        chk("en_off_mode_live", int'(mode_o), 1);
        en = 1'b1;
        tick(1);
        chk("en_on_b1", int'(voice_busy_o), 4'b0001);
        chk("en_on_ph0", int'(dut.phase_q[0]), 0);
        tick(1);
        chk("en_on_b2", int'(voice_busy_o), 4'b0011);
        chk("en_on_ph1", int'(dut.phase_q[0]), 439);
        tick(1);
        chk("en_on_b3", int'(voice_busy_o), 4'b0111);
        tick(300);

        // Asynchronous reset mid-note
        #2 n_rst = 1'b0;
        #1;
        chk("arst_busy", int'(voice_busy_o), 0);
        chk("arst_mode", int'(mode_o), 0);
        chk("arst_pwm", int'(pwm_o), 0);
        tick(3);
        chk("arst_hold_busy", int'(voice_busy_o), 0);
        chk("arst_hold_pwm", int'(pwm_o), 0);
        n_rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
